parity_lane_pipe: RTL and testbench

//  Streaming per-lane parity generator/checker with valid/ready handshake and one output register.

---
 rtl/parity_lane_pipe.sv | 79 +++++++
 tb/tb_parity_lane_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_lane_pipe.sv
// parity_lane_pipe: registered per-lane parity generator/checker with valid/ready handshake.
// Define PARITY_ERR_CNT_EN to add the saturating erroneous-word counter on err_cnt.
module parity_lane_pipe #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16,
  localparam int LW    = (LANE_W < 1) ? 1 : LANE_W,
  localparam int LANES = DATA_W / LW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              odd_mode,
  input  logic              chk_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LANES-1:0]  in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LANES-1:0]  out_par,
  output logic [LANES-1:0]  out_err,
  input  logic              err_clr,
  output logic              err_sticky
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt
`endif
);
  if (LANE_W < 1 || (DATA_W % LW) != 0 || CNT_W < 1) begin : g_bad_cfg
    $error("parity_lane_pipe: DATA_W must be a positive multiple of LANE_W, CNT_W >= 1");
  end
  logic              valid_q, sticky_q, sticky_d, xfer, err_ev;
  logic [DATA_W-1:0] data_q;
  logic [LANES-1:0]  par_q, err_q, p, par_d, err_d;
  assign in_ready = !valid_q || out_ready;
  assign xfer     = in_valid && in_ready;
  always_comb begin
    p = '0;
    for (int k = 0; k < LANES; k++) p[k] = ^in_data[k*LW +: LW] ^ odd_mode;
  end
  assign par_d    = chk_mode ? in_par : p;
  assign err_d    = chk_mode ? p ^ in_par : '0;
  assign err_ev   = xfer && chk_mode && |err_d;
  // a new error in the same cycle as err_clr must survive the clear
  assign sticky_d = err_ev || (sticky_q && !err_clr);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      par_q    <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (in_ready) valid_q <= in_valid;
      if (xfer) begin
        data_q <= in_data;
        par_q  <= par_d;
        err_q  <= err_d;
      end
      sticky_q <= sticky_d;
    end
  end
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_par    = par_q;
  assign out_err    = err_q;
  assign err_sticky = sticky_q;
`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = err_clr ? CNT_W'(err_ev) : (err_ev && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign err_cnt = cnt_q;
`else
`endif
endmodule

// File: tb/tb_parity_lane_pipe.sv
// tb_parity_lane_pipe: table vectors plus scoreboarded random traffic for parity_lane_pipe.
module tb_parity_lane_pipe;
  logic        clk = 1'b0;
  logic        reset, odd_mode, chk_mode, in_valid, out_ready, err_clr;
  logic        in_ready, out_valid, err_sticky;
  logic [31:0] in_data, out_data;
  logic [3:0]  in_par, out_par, out_err;
`ifdef PARITY_ERR_CNT_EN
  logic [1:0]  err_cnt;
`endif

  parity_lane_pipe #(.DATA_W(32), .LANE_W(8), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .odd_mode(odd_mode), .chk_mode(chk_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_par(out_par), .out_err(out_err), .err_clr(err_clr), .err_sticky(err_sticky)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] d; logic [3:0] p; logic [3:0] e;} exp_t;
  typedef struct packed {logic odd; logic chk; logic [31:0] d; logic [3:0] p; logic [3:0] ep; logic [3:0] ee;} vec_t;

  exp_t q[$];
  int   nvec = 0, nmis = 0, n_xfer = 0, m_cnt = 0;
  logic m_sticky = 1'b0;

  function automatic logic [3:0] par_of(input logic [31:0] d, input logic odd);
    logic [3:0] r;
    r = {4{odd}};
    for (int b = 0; b < 32; b++) if (d[b]) r[b/8] = ~r[b/8];
    return r;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Called at a negedge with inputs driven; scores the upcoming rising edge.
  task automatic tick();
    exp_t x;
    logic [3:0] p;
    logic ev;
    #1;
    chk("err_sticky", {63'd0, err_sticky}, {63'd0, m_sticky});
`ifdef PARITY_ERR_CNT_EN
    chk("err_cnt", {62'd0, err_cnt}, 64'(m_cnt));
`endif
    if (reset) begin
      q.delete();
      m_sticky = 1'b0;
      m_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          x = q.pop_front();
          chk("sb_data", {32'd0, out_data}, {32'd0, x.d});
          chk("sb_par", {60'd0, out_par}, {60'd0, x.p});
          chk("sb_err", {60'd0, out_err}, {60'd0, x.e});
        end
      end
      ev = 1'b0;
      if (in_valid && in_ready) begin
        p = par_of(in_data, odd_mode);
        x.d = in_data;
        x.p = chk_mode ? in_par : p;
        x.e = chk_mode ? (p ^ in_par) : 4'd0;
        q.push_back(x);
        n_xfer++;
        ev = chk_mode && (x.e != 4'd0);
      end
      m_cnt = err_clr ? (ev ? 1 : 0) : ((ev && m_cnt < 3) ? m_cnt + 1 : m_cnt);
      m_sticky = ev | (m_sticky & ~err_clr);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic chk_m, input logic odd, input logic [31:0] d, input logic [3:0] p);
    in_valid = v; chk_mode = chk_m; odd_mode = odd; in_data = d; in_par = p;
  endtask

  vec_t vt[8];
  logic [31:0] held_d;
  logic [3:0]  held_p, held_e;
  int cyc;

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h0103_00FF, 4'b0000, 4'b1000, 4'b0000};
    vt[1] = '{1'b1, 1'b0, 32'h0103_00FF, 4'b0000, 4'b0111, 4'b0000};
    vt[2] = '{1'b0, 1'b1, 32'h0103_00FF, 4'b1001, 4'b1001, 4'b0001};
    vt[3] = '{1'b0, 1'b0, 32'h0000_0000, 4'b1111, 4'b0000, 4'b0000};
    vt[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 4'b0000, 4'b1111, 4'b0000};
    vt[5] = '{1'b1, 1'b1, 32'h8000_0001, 4'b0110, 4'b0110, 4'b0000};
    vt[6] = '{1'b0, 1'b0, 32'h1234_5678, 4'b0000, 4'b0100, 4'b0000};
    vt[7] = '{1'b0, 1'b1, 32'hA5A5_A5A7, 4'b0000, 4'b0000, 4'b0001};

    reset = 1'b1; out_ready = 1'b1; err_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    repeat (2) @(negedge clk);
    tick();
    reset = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_par", {60'd0, out_par}, 64'd0);
    chk("rst_out_err", {60'd0, out_err}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vt[i].chk, vt[i].odd, vt[i].d, vt[i].p);
      tick();
      chk("vec_valid", {63'd0, out_valid}, 64'd1);
      chk("vec_par", {60'd0, out_par}, {60'd0, vt[i].ep});
      chk("vec_err", {60'd0, out_err}, {60'd0, vt[i].ee});
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    tick();
    chk("drop_valid", {63'd0, out_valid}, 64'd0);
    chk("drop_hold_data", {32'd0, out_data}, 64'hA5A5_A5A7);
    chk("drop_hold_err", {60'd0, out_err}, 64'd1);
    chk("sticky_set", {63'd0, err_sticky}, 64'd1);
`ifdef PARITY_ERR_CNT_EN
    chk("cnt_two", {62'd0, err_cnt}, 64'd2);
`endif

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_sticky", {63'd0, err_sticky}, 64'd0);

    // clear and error in the same cycle: the error wins
    err_clr = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0103_00FF, 4'b1001);
    tick();
    err_clr = 1'b0;
    chk("clr_vs_err_sticky", {63'd0, err_sticky}, 64'd1);
`ifdef PARITY_ERR_CNT_EN
    chk("clr_vs_err_cnt", {62'd0, err_cnt}, 64'd1);
`endif

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0100 + i, 4'b0000);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    tick();
`ifdef PARITY_ERR_CNT_EN
    chk("cnt_saturated", {62'd0, err_cnt}, 64'd3);
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_after_sat_sticky", {63'd0, err_sticky}, 64'd0);
`ifdef PARITY_ERR_CNT_EN
    chk("clr_after_sat_cnt", {62'd0, err_cnt}, 64'd0);
`endif

    drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'd0);
    tick();
    held_d = out_data; held_p = out_par; held_e = out_err;
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'hCAFE_F00D, 4'b1010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_data", {32'd0, out_data}, {32'd0, held_d});
      chk("bp_par", {60'd0, out_par}, {60'd0, held_p});
      chk("bp_err", {60'd0, out_err}, {60'd0, held_e});
    end
    chk("bp_data_value", {32'd0, held_d}, 64'hDEAD_BEEF);
    out_ready = 1'b1;
    tick();
    chk("bp_release_data", {32'd0, out_data}, 64'hCAFE_F00D);

    cyc = 0;
    begin
      int target;
      target = n_xfer + 100;
      while (n_xfer < target && cyc < 2000) begin
        if (!(in_valid && !in_ready))
          drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom, 4'($urandom_range(0, 15)));
        out_ready = $urandom_range(0, 3) != 0;
        err_clr = $urandom_range(0, 15) == 0;
        tick();
        cyc++;
      end
      chk("rand_100_words", 64'(n_xfer >= target), 64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) tick();
    chk("sb_drained", 64'(q.size()), 64'd0);

    drive(1'b1, 1'b1, 1'b0, 32'h1111_2222, 4'b0000);
    tick();
    out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data", {32'd0, out_data}, 64'd0);
    chk("mid_rst_par", {60'd0, out_par}, 64'd0);
    chk("mid_rst_err", {60'd0, out_err}, 64'd0);
    chk("mid_rst_sticky", {63'd0, err_sticky}, 64'd0);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h0F0F_0001, 4'd0);
    tick();
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_data", {32'd0, out_data}, 64'h0F0F_0001);
    chk("post_rst_par", {60'd0, out_par}, 64'b0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_1110);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    repeat (2) tick();
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
